// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory arbiter slice.
// Contents:
//   - RV32 load/store funct3 encodings. Store codes alias the matching load codes.
//   - Arbiter FSM state type (idle / DMA-locked).
package dmem_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_DLOCK = 1'b1
  } state_t;

endpackage

// File: rtl/dmem_arbiter_if.sv
// Bus bundle between the two requesters, the arbiter and the data memory.
// Signal groups:
//   - C_*: core load/store requester (request fields in, grant/response out).
//   - D_*: program/DMA loader, the same set plus D_LOCK for burst locking.
//   - M_*: memory side. Strobes, FUNC3, address and write data go to the memory;
//     M_RDATA is its combinational read data.
// Modports:
//   - slave: the arbiter's view.
//   - master: the requesters' and memory's view.
interface dmem_arbiter_if;

  logic        C_REQ;
  logic        C_WE;
  logic [2:0]  C_FUNC3;
  logic [31:0] C_ADDR;
  logic [31:0] C_WDATA;
  logic        C_GNT;
  logic        C_RVALID;
  logic [31:0] C_RDATA;
  logic        C_ERR;

  logic        D_REQ;
  logic        D_WE;
  logic [2:0]  D_FUNC3;
  logic [31:0] D_ADDR;
  logic [31:0] D_WDATA;
  logic        D_LOCK;
  logic        D_GNT;
  logic        D_RVALID;
  logic [31:0] D_RDATA;
  logic        D_ERR;

  logic        M_RD;
  logic        M_WRT;
  logic [2:0]  M_FUNC3;
  logic [31:0] M_ADDR;
  logic [31:0] M_WDATA;
  logic [31:0] M_RDATA;

  modport slave (
    input  C_REQ, C_WE, C_FUNC3, C_ADDR, C_WDATA,
    output C_GNT, C_RVALID, C_RDATA, C_ERR,
    input  D_REQ, D_WE, D_FUNC3, D_ADDR, D_WDATA, D_LOCK,
    output D_GNT, D_RVALID, D_RDATA, D_ERR,
    output M_RD, M_WRT, M_FUNC3, M_ADDR, M_WDATA,
    input  M_RDATA
  );

  modport master (
    output C_REQ, C_WE, C_FUNC3, C_ADDR, C_WDATA,
    input  C_GNT, C_RVALID, C_RDATA, C_ERR,
    output D_REQ, D_WE, D_FUNC3, D_ADDR, D_WDATA, D_LOCK,
    input  D_GNT, D_RVALID, D_RDATA, D_ERR,
    input  M_RD, M_WRT, M_FUNC3, M_ADDR, M_WDATA,
    output M_RDATA
  );

endinterface

// File: rtl/dmem_access_check.sv
// Combinational legality check for one memory access.
// Ports:
//   - func3_i: RV32 load/store funct3.
//   - addr_i:  byte address.
//   - err_o:   1 when the access is misaligned, uses an undefined funct3,
//              or falls outside the DEPTH-word memory.
module dmem_access_check
  import dmem_pkg::*;
#(
  parameter int DEPTH = 512
) (
  input  logic [2:0]  func3_i,
  input  logic [31:0] addr_i,
  output logic        err_o
);

  localparam logic [31:0] ADDR_LIMIT = 32'(4 * DEPTH);

  logic misalign;

  // Store encodings share values with loads (SB=LB, SH=LH, SW=LW), so the
  // load names cover both directions.
  always_comb begin
    misalign = 1'b0;
    case (func3_i)
      F3_LB, F3_LBU: misalign = 1'b0;
      F3_LH, F3_LHU: misalign = addr_i[0];
      F3_LW:         misalign = |addr_i[1:0];
      default:       misalign = 1'b1;
    endcase
  end

  assign err_o = misalign | (addr_i >= ADDR_LIMIT);

endmodule

// File: rtl/dmem_arbiter.sv
// Two-requester arbiter in front of the single-port data memory.
// Ports:
//   - CLK, RESET: clock and synchronous active-high reset.
//   - bus:        C_* core, D_* DMA and M_* memory signals.
// Arbitration order:
//   1. DMA-locked burst.
//   2. Starved DMA.
//   3. Core.
//   4. DMA.
// Grants are combinational. Responses (RVALID/ERR/RDATA) arrive one cycle later.
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int DEPTH      = 512,
  parameter int STARVE_MAX = 8,
  parameter int BURST_MAX  = 16
) (
  input logic           CLK,
  input logic           RESET,
  dmem_arbiter_if.slave bus
);

  localparam int SW_W = $clog2(STARVE_MAX + 1);
  localparam int BW   = $clog2(BURST_MAX + 1);

  state_t          state_q, state_d;
  logic [SW_W-1:0] starve_q, starve_d;
  logic [BW-1:0]   burst_q, burst_d, burst_inc;

  logic        c_gnt, d_gnt, any_gnt, acc_err;
  logic        sel_we;
  logic [2:0]  sel_func3;
  logic [31:0] sel_addr, sel_wdata;

  logic        c_rvalid_q, c_rvalid_d, c_err_q, c_err_d;
  logic        d_rvalid_q, d_rvalid_d, d_err_q, d_err_d;
  logic [31:0] c_rdata_q, c_rdata_d, d_rdata_q, d_rdata_d;

  // Grant selection; nothing is granted while reset is held.
  always_comb begin
    c_gnt = 1'b0;
    d_gnt = 1'b0;
    if (!RESET) begin
      if (state_q == ST_DLOCK)
        d_gnt = bus.D_REQ;
      else if (bus.D_REQ && (starve_q == SW_W'(STARVE_MAX)))
        d_gnt = 1'b1;
      else if (bus.C_REQ)
        c_gnt = 1'b1;
      else if (bus.D_REQ)
        d_gnt = 1'b1;
    end
  end

  assign any_gnt   = c_gnt | d_gnt;
  assign sel_we    = d_gnt ? bus.D_WE    : bus.C_WE;
  assign sel_func3 = d_gnt ? bus.D_FUNC3 : bus.C_FUNC3;
  assign sel_addr  = d_gnt ? bus.D_ADDR  : bus.C_ADDR;
  assign sel_wdata = d_gnt ? bus.D_WDATA : bus.C_WDATA;

  dmem_access_check #(.DEPTH(DEPTH)) u_check (
    .func3_i (sel_func3),
    .addr_i  (sel_addr),
    .err_o   (acc_err)
  );

  // Memory drive. A rejected access is still granted, but it never strobes the memory.
  always_comb begin
    bus.M_RD    = 1'b0;
    bus.M_WRT   = 1'b0;
    bus.M_FUNC3 = 3'b000;
    bus.M_ADDR  = '0;
    bus.M_WDATA = '0;
    if (any_gnt) begin
      bus.M_RD    = !acc_err && !sel_we;
      bus.M_WRT   = !acc_err && sel_we;
      bus.M_FUNC3 = sel_func3;
      bus.M_ADDR  = sel_addr;
      bus.M_WDATA = sel_wdata;
    end
  end

  assign burst_inc = burst_q + BW'(1);

  // Lock FSM and burst counter.
  always_comb begin
    state_d = state_q;
    burst_d = burst_q;
    case (state_q)
      ST_IDLE: begin
        burst_d = '0;
        if (d_gnt && bus.D_LOCK) state_d = ST_DLOCK;
      end
      ST_DLOCK: begin
        if (!bus.D_REQ || !bus.D_LOCK || (burst_inc == BW'(BURST_MAX))) begin
          state_d = ST_IDLE;
          burst_d = '0;
        end else begin
          burst_d = burst_inc;
        end
      end
      default: begin
        state_d = ST_IDLE;
        burst_d = '0;
      end
    endcase
  end

  // Starvation counter: counts waiting cycles of a requesting DMA and saturates.
  always_comb begin
    starve_d = starve_q;
    if (!bus.D_REQ || d_gnt)
      starve_d = '0;
    else if (starve_q != SW_W'(STARVE_MAX))
      starve_d = starve_q + SW_W'(1);
  end

  // Responses. Read data is captured at the edge that ends the granted cycle.
  always_comb begin
    c_rvalid_d = c_gnt;
    c_err_d    = c_gnt & acc_err;
    c_rdata_d  = c_rdata_q;
    if (c_gnt) c_rdata_d = (acc_err || sel_we) ? '0 : bus.M_RDATA;
    d_rvalid_d = d_gnt;
    d_err_d    = d_gnt & acc_err;
    d_rdata_d  = d_rdata_q;
    if (d_gnt) d_rdata_d = (acc_err || sel_we) ? '0 : bus.M_RDATA;
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q    <= ST_IDLE;
      starve_q   <= '0;
      burst_q    <= '0;
      c_rvalid_q <= 1'b0;
      c_err_q    <= 1'b0;
      c_rdata_q  <= '0;
      d_rvalid_q <= 1'b0;
      d_err_q    <= 1'b0;
      d_rdata_q  <= '0;
    end else begin
      state_q    <= state_d;
      starve_q   <= starve_d;
      burst_q    <= burst_d;
      c_rvalid_q <= c_rvalid_d;
      c_err_q    <= c_err_d;
      c_rdata_q  <= c_rdata_d;
      d_rvalid_q <= d_rvalid_d;
      d_err_q    <= d_err_d;
      d_rdata_q  <= d_rdata_d;
    end
  end

  assign bus.C_GNT    = c_gnt;
  assign bus.C_RVALID = c_rvalid_q;
  assign bus.C_ERR    = c_err_q;
  assign bus.C_RDATA  = c_rdata_q;
  assign bus.D_GNT    = d_gnt;
  assign bus.D_RVALID = d_rvalid_q;
  assign bus.D_ERR    = d_err_q;
  assign bus.D_RDATA  = d_rdata_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter (DEPTH=512, STARVE_MAX=4, BURST_MAX=16).
// A simple byte-addressed memory model answers the M_* bus.
module tb_dmem_arbiter;
  import dmem_pkg::*;

  typedef struct packed {
    logic        req;
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
  } req_t;

  // comb = {C_GNT, D_GNT, M_RD, M_WRT} in the cycle.
  // cflg/dflg = {RVALID, ERR} after the edge.
  // crd/drd = RDATA, checked when RVALID is expected.
  typedef struct packed {
    req_t        c;
    req_t        d;
    logic        lock;
    logic        rst;
    logic [3:0]  comb;
    logic [1:0]  cflg;
    logic [31:0] crd;
    logic [1:0]  dflg;
    logic [31:0] drd;
  } vec_t;

  localparam req_t NOREQ = '0;

  logic CLK = 1'b0;
  logic RESET;
  logic mem_clr;
  int   checks = 0;
  int   failures = 0;

  dmem_arbiter_if bus ();

  dmem_arbiter #(.DEPTH(512), .STARVE_MAX(4), .BURST_MAX(16)) dut (
    .CLK   (CLK),
    .RESET (RESET),
    .bus   (bus)
  );

  always #5 CLK = ~CLK;

  // Memory model: combinational read with RV32 load extension, store at the clock edge.
  logic [31:0] mem [0:511];
  logic [31:0] rd_word, rd_shift;

  always_comb begin
    rd_word     = mem[bus.M_ADDR[10:2]];
    rd_shift    = rd_word >> {bus.M_ADDR[1:0], 3'b000};
    bus.M_RDATA = rd_word;
    case (bus.M_FUNC3)
      3'b000:  bus.M_RDATA = {{24{rd_shift[7]}}, rd_shift[7:0]};
      3'b001:  bus.M_RDATA = {{16{rd_shift[15]}}, rd_shift[15:0]};
      3'b100:  bus.M_RDATA = {24'h0, rd_shift[7:0]};
      3'b101:  bus.M_RDATA = {16'h0, rd_shift[15:0]};
      default: bus.M_RDATA = rd_word;
    endcase
  end

  always @(posedge CLK) begin
    if (mem_clr) begin
      for (int i = 0; i < 512; i++) mem[i] <= '0;
    end else if (bus.M_WRT) begin
      case (bus.M_FUNC3[1:0])
        2'b00:   mem[bus.M_ADDR[10:2]][{bus.M_ADDR[1:0], 3'b000} +: 8] <= bus.M_WDATA[7:0];
        2'b01:   mem[bus.M_ADDR[10:2]][{bus.M_ADDR[1], 4'b0000} +: 16] <= bus.M_WDATA[15:0];
        default: mem[bus.M_ADDR[10:2]] <= bus.M_WDATA;
      endcase
    end
  end

  function automatic req_t rq(logic we, logic [2:0] f3, logic [31:0] a, logic [31:0] wd);
    rq = '{req: 1'b1, we: we, f3: f3, addr: a, wdata: wd};
  endfunction

  function automatic vec_t mk(req_t c, req_t d, logic lock, logic rst, logic [3:0] comb,
                              logic [1:0] cflg, logic [31:0] crd, logic [1:0] dflg,
                              logic [31:0] drd);
    mk = '{c: c, d: d, lock: lock, rst: rst, comb: comb, cflg: cflg, crd: crd,
           dflg: dflg, drd: drd};
  endfunction

  task automatic chk(input string name, input string what, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s %s actual=0x%08h required=0x%08h", name, what, act, exp);
    end
  endtask

  // Drive one cycle, check the combinational outputs, then the registered response.
  task automatic run_vec(input vec_t v, input string name);
    RESET       = v.rst;
    bus.C_REQ   = v.c.req;  bus.C_WE = v.c.we;  bus.C_FUNC3 = v.c.f3;
    bus.C_ADDR  = v.c.addr; bus.C_WDATA = v.c.wdata;
    bus.D_REQ   = v.d.req;  bus.D_WE = v.d.we;  bus.D_FUNC3 = v.d.f3;
    bus.D_ADDR  = v.d.addr; bus.D_WDATA = v.d.wdata;
    bus.D_LOCK  = v.lock;
    #1;
    chk(name, "C_GNT", 32'(bus.C_GNT), 32'(v.comb[3]));
    chk(name, "D_GNT", 32'(bus.D_GNT), 32'(v.comb[2]));
    chk(name, "M_RD",  32'(bus.M_RD),  32'(v.comb[1]));
    chk(name, "M_WRT", 32'(bus.M_WRT), 32'(v.comb[0]));
    if (v.comb[3] | v.comb[2]) begin
      chk(name, "M_ADDR",  bus.M_ADDR,  v.comb[3] ? v.c.addr  : v.d.addr);
      chk(name, "M_WDATA", bus.M_WDATA, v.comb[3] ? v.c.wdata : v.d.wdata);
    end else begin
      chk(name, "M_bus_idle", bus.M_ADDR | bus.M_WDATA | 32'(bus.M_FUNC3), 32'h0);
    end
    @(posedge CLK);
    #1;
    chk(name, "C_RVALID", 32'(bus.C_RVALID), 32'(v.cflg[1]));
    chk(name, "C_ERR",    32'(bus.C_ERR),    32'(v.cflg[0]));
    chk(name, "D_RVALID", 32'(bus.D_RVALID), 32'(v.dflg[1]));
    chk(name, "D_ERR",    32'(bus.D_ERR),    32'(v.dflg[0]));
    if (v.cflg[1]) chk(name, "C_RDATA", bus.C_RDATA, v.crd);
    if (v.dflg[1]) chk(name, "D_RDATA", bus.D_RDATA, v.drd);
    $display("vec %s: rst=%b cgnt=%b dgnt=%b crv=%b cerr=%b crd=%08h drv=%b derr=%b drd=%08h",
             name, v.rst, v.comb[3], v.comb[2], bus.C_RVALID, bus.C_ERR, bus.C_RDATA,
             bus.D_RVALID, bus.D_ERR, bus.D_RDATA);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout actual=running required=finished");
    $fatal(1);
  end

  vec_t tbl [0:16];
  logic dmawin;

  initial begin
    // Straight-line table: store/load, errors, byte lanes, contention.
    tbl[0]  = mk(rq(1'b1, F3_SW, 32'h10, 32'hDEADBEEF), NOREQ, 1'b0, 1'b0, 4'b1001, 2'b10, 32'h0, 2'b00, 32'h0);
    tbl[1]  = mk(rq(1'b0, F3_LW, 32'h10, 32'h0), NOREQ, 1'b0, 1'b0, 4'b1010, 2'b10, 32'hDEADBEEF, 2'b00, 32'h0);
    tbl[2]  = mk(NOREQ, NOREQ, 1'b0, 1'b0, 4'b0000, 2'b00, 32'h0, 2'b00, 32'h0);
    tbl[3]  = mk(rq(1'b0, F3_LH, 32'h13, 32'h0), NOREQ, 1'b0, 1'b0, 4'b1000, 2'b11, 32'h0, 2'b00, 32'h0);
    tbl[4]  = mk(rq(1'b1, F3_SW, 32'h800, 32'h12345678), NOREQ, 1'b0, 1'b0, 4'b1000, 2'b11, 32'h0, 2'b00, 32'h0);
    tbl[5]  = mk(rq(1'b0, F3_LW, 32'h0, 32'h0), NOREQ, 1'b0, 1'b0, 4'b1010, 2'b10, 32'h0, 2'b00, 32'h0);
    tbl[6]  = mk(NOREQ, rq(1'b1, F3_SW, 32'h20, 32'h11223344), 1'b0, 1'b0, 4'b0101, 2'b00, 32'h0, 2'b10, 32'h0);
    tbl[7]  = mk(NOREQ, rq(1'b1, F3_SB, 32'h21, 32'h80), 1'b0, 1'b0, 4'b0101, 2'b00, 32'h0, 2'b10, 32'h0);
    tbl[8]  = mk(rq(1'b0, F3_LB, 32'h21, 32'h0), NOREQ, 1'b0, 1'b0, 4'b1010, 2'b10, 32'hFFFFFF80, 2'b00, 32'h0);
    tbl[9]  = mk(rq(1'b0, F3_LBU, 32'h21, 32'h0), NOREQ, 1'b0, 1'b0, 4'b1010, 2'b10, 32'h00000080, 2'b00, 32'h0);
    tbl[10] = mk(rq(1'b0, F3_LW, 32'h20, 32'h0), NOREQ, 1'b0, 1'b0, 4'b1010, 2'b10, 32'h11228044, 2'b00, 32'h0);
    tbl[11] = mk(rq(1'b0, F3_LW, 32'h10, 32'h0), rq(1'b0, F3_LW, 32'h20, 32'h0), 1'b0, 1'b0, 4'b1010, 2'b10, 32'hDEADBEEF, 2'b00, 32'h0);
    tbl[12] = mk(NOREQ, rq(1'b0, F3_LW, 32'h20, 32'h0), 1'b0, 1'b0, 4'b0110, 2'b00, 32'h0, 2'b10, 32'h11228044);
    tbl[13] = mk(NOREQ, rq(1'b0, 3'b011, 32'h0, 32'h0), 1'b0, 1'b0, 4'b0100, 2'b00, 32'h0, 2'b11, 32'h0);
    tbl[14] = mk(NOREQ, rq(1'b1, F3_SW, 32'h22, 32'h5), 1'b0, 1'b0, 4'b0100, 2'b00, 32'h0, 2'b11, 32'h0);
    tbl[15] = mk(rq(1'b0, F3_LHU, 32'h22, 32'h0), NOREQ, 1'b0, 1'b0, 4'b1010, 2'b10, 32'h00001122, 2'b00, 32'h0);
    tbl[16] = mk(NOREQ, NOREQ, 1'b0, 1'b0, 4'b0000, 2'b00, 32'h0, 2'b00, 32'h0);

    mem_clr = 1'b1;
    RESET   = 1'b1;
    bus.C_REQ = 1'b0; bus.C_WE = 1'b0; bus.C_FUNC3 = 3'b0; bus.C_ADDR = '0; bus.C_WDATA = '0;
    bus.D_REQ = 1'b0; bus.D_WE = 1'b0; bus.D_FUNC3 = 3'b0; bus.D_ADDR = '0; bus.D_WDATA = '0;
    bus.D_LOCK = 1'b0;
    @(posedge CLK);
    #1;
    mem_clr = 1'b0;

    // Reset held with requests pending: nothing may be granted or strobed.
    for (int i = 0; i < 2; i++)
      run_vec(mk(rq(1'b0, F3_LW, 32'h10, 32'h0), rq(1'b1, F3_SW, 32'h4, 32'h9), 1'b1, 1'b1,
                 4'b0000, 2'b00, 32'h0, 2'b00, 32'h0), "reset");
    chk("reset", "C_RDATA", bus.C_RDATA, 32'h0);
    chk("reset", "D_RDATA", bus.D_RDATA, 32'h0);

    for (int i = 0; i < 17; i++) run_vec(tbl[i], $sformatf("tbl%0d", i));

    // Starvation: core wins four cycles, DMA overrides in the fifth, core again in the sixth.
    for (int i = 0; i < 6; i++) begin
      dmawin = (i == 4);
      run_vec(mk(rq(1'b0, F3_LW, 32'h10, 32'h0), rq(1'b0, F3_LW, 32'h20, 32'h0), 1'b0, 1'b0,
                 dmawin ? 4'b0110 : 4'b1010, dmawin ? 2'b00 : 2'b10, 32'hDEADBEEF,
                 dmawin ? 2'b10 : 2'b00, 32'h11228044), $sformatf("starve%0d", i));
    end
    run_vec(tbl[16], "idle");

    // Locked DMA burst of three stores holds off a requesting core.
    run_vec(mk(NOREQ, rq(1'b1, F3_SW, 32'h40, 32'hA1), 1'b1, 1'b0, 4'b0101, 2'b00, 32'h0, 2'b10, 32'h0), "burst1");
    run_vec(mk(rq(1'b0, F3_LW, 32'h10, 32'h0), rq(1'b1, F3_SW, 32'h44, 32'hA2), 1'b1, 1'b0, 4'b0101, 2'b00, 32'h0, 2'b10, 32'h0), "burst2");
    run_vec(mk(rq(1'b0, F3_LW, 32'h10, 32'h0), rq(1'b1, F3_SW, 32'h48, 32'hA3), 1'b0, 1'b0, 4'b0101, 2'b00, 32'h0, 2'b10, 32'h0), "burst3");
    run_vec(mk(rq(1'b0, F3_LW, 32'h10, 32'h0), NOREQ, 1'b0, 1'b0, 4'b1010, 2'b10, 32'hDEADBEEF, 2'b00, 32'h0), "burst_core");
    run_vec(mk(rq(1'b0, F3_LW, 32'h44, 32'h0), NOREQ, 1'b0, 1'b0, 4'b1010, 2'b10, 32'hA2, 2'b00, 32'h0), "burst_rd");

    // Reset during beat 2 of a locked burst: beat 2 is dropped, core is served next.
    run_vec(mk(NOREQ, rq(1'b1, F3_SW, 32'h50, 32'hB1), 1'b1, 1'b0, 4'b0101, 2'b00, 32'h0, 2'b10, 32'h0), "rst_beat1");
    run_vec(mk(rq(1'b0, F3_LW, 32'h10, 32'h0), rq(1'b1, F3_SW, 32'h54, 32'hB2), 1'b1, 1'b1, 4'b0000, 2'b00, 32'h0, 2'b00, 32'h0), "rst_beat2");
    run_vec(mk(rq(1'b0, F3_LW, 32'h10, 32'h0), rq(1'b1, F3_SW, 32'h54, 32'hB2), 1'b1, 1'b0, 4'b1010, 2'b10, 32'hDEADBEEF, 2'b00, 32'h0), "rst_after");
    run_vec(mk(rq(1'b0, F3_LW, 32'h54, 32'h0), NOREQ, 1'b0, 1'b0, 4'b1010, 2'b10, 32'h0, 2'b00, 32'h0), "rst_nowrite");
    run_vec(mk(rq(1'b0, F3_LW, 32'h50, 32'h0), NOREQ, 1'b0, 1'b0, 4'b1010, 2'b10, 32'hB1, 2'b00, 32'h0), "rst_beat1_rd");
    run_vec(tbl[16], "idle_end");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
